// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched bit pattern MSB-first, optionally
// repeated with idle gaps between copies, and pulses done once at the end.
module sequence_generator #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MAX_LEN-1:0]         pattern,
  input  logic [$clog2(MAX_LEN):0]   len,
  input  logic [3:0]                 rpt,
  output logic                       Out,
  output logic                       bit_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned LW = IW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [IW-1:0]        top_q, top_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           rpt_q, rpt_d;
  logic [3:0]           gap_q, gap_d;
  logic                 out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Outputs are computed for the state being entered, so they are valid
  // in the same cycle the FSM occupies that state.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    top_d   = top_q;
    idx_d   = idx_q;
    rpt_d   = rpt_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && (len != '0)) begin
          pat_d   = pattern;
          top_d   = (len > LW'(MAX_LEN)) ? IW'(MAX_LEN - 1) : IW'(len - 1'b1);
          rpt_d   = rpt;
          idx_d   = top_d;
          state_d = SEND;
          out_d   = pattern[top_d];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
          out_d   = pat_q[idx_d];
          valid_d = 1'b1;
        end else if (rpt_q != '0) begin
          rpt_d = rpt_q - 1'b1;
          if (GAP_CYCLES == 0) begin
            idx_d   = top_q;
            out_d   = pat_q[top_q];
            valid_d = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYCLES - 1);
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = SEND;
          idx_d   = top_q;
          out_d   = pat_q[top_q];
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      top_q   <= '0;
      idx_q   <= '0;
      rpt_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      top_q   <= top_d;
      idx_q   <= idx_d;
      rpt_q   <= rpt_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Out       = out_q;
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: directed scenarios plus random
// transactions compared cycle by cycle against a per-cycle expectation queue.
module tb_sequence_generator;

  localparam int unsigned ML   = 16;
  localparam int unsigned GAPC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  rpt;
  logic        Out, bit_valid, busy, done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {logic o; logic v; logic b; logic d;} exp_t;
  exp_t exp_q[$];

  sequence_generator #(.MAX_LEN(ML), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .rpt(rpt), .Out(Out), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic o, input logic v, input logic b, input logic d);
    exp_t e;
    e.o = o; e.v = v; e.b = b; e.d = d;
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle outputs of one transaction, straight from the rules:
  // (rpt+1) copies of the pattern MSB-first, gaps between copies, one done cycle.
  function automatic void add_txn(input logic [15:0] p, input int unsigned l, input int unsigned r);
    int unsigned eff;
    eff = (l > ML) ? ML : l;
    if (eff == 0) return;
    for (int unsigned k = 0; k <= r; k++) begin
      for (int i = int'(eff) - 1; i >= 0; i--) push(p[4'(i)], 1'b1, 1'b1, 1'b0);
      if (k < r) for (int unsigned g = 0; g < GAPC; g++) push(1'b0, 1'b0, 1'b1, 1'b0);
    end
    push(1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic launch(input logic [15:0] p, input int unsigned l, input int unsigned r);
    start   = 1'b1;
    pattern = p;
    len     = 5'(l);
    rpt     = 4'(r);
    add_txn(p, l, r);
  endtask

  // mode 0: drop start after each cycle; 1: scramble inputs while busy; 2: leave inputs alone
  task automatic play(input int mode, input string name, input int unsigned max_n);
    exp_t e;
    int unsigned n = 0;
    while (exp_q.size() > 0 && n < max_n) begin
      e = exp_q.pop_front();
      n++;
      @(posedge clk); #1;
      check({name, "_out"},   32'(Out),       32'(e.o));
      check({name, "_valid"}, 32'(bit_valid), 32'(e.v));
      check({name, "_busy"},  32'(busy),      32'(e.b));
      check({name, "_done"},  32'(done),      32'(e.d));
      if (mode == 1 && e.b && !e.d) begin
        start   = 1'($urandom);
        pattern = 16'($urandom);
        len     = 5'($urandom);
        rpt     = 4'($urandom);
      end else if (mode != 2) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
    play(0, name, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; rpt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out",   32'(Out),       32'd0);
    check("reset_valid", 32'(bit_valid), 32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    check("reset_done",  32'(done),      32'd0);
    rst = 1'b0;
    idle_cycles("post_reset_idle", 2);

    launch(16'b0000_0001_0011_0100, 12, 0);
    play(0, "txn12", 1000);

    launch(16'h0009, 4, 2);
    play(0, "rpt2_gap", 1000);

    start = 1'b1; len = '0; pattern = 16'hFFFF; rpt = 4'd1;
    for (int unsigned i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
    play(2, "len0", 100);
    start = 1'b0;

    launch(16'hB3C5, 20, 0);
    play(0, "len_clamp", 1000);

    launch(16'h5A3C, 9, 1);
    play(1, "busy_scramble", 1000);

    launch(16'h00A6, 8, 1);
    play(0, "pre_rst", 3);
    rst = 1'b1; start = 1'b1; len = 5'd4;
    @(posedge clk); #1;
    check("rst_out",   32'(Out),       32'd0);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    idle_cycles("after_rst", 12);
    launch(16'h00A6, 8, 1);
    play(0, "after_rst_txn", 1000);

    start = 1'b1; pattern = 16'h0005; len = 5'd3; rpt = '0;
    for (int unsigned k = 0; k < 3; k++) add_txn(16'h0005, 3, 0);
    play(2, "held_start", 1000);
    start = 1'b0;
    idle_cycles("held_end", 2);

    for (int t = 0; t < 25; t++) begin
      launch(16'($urandom), $urandom_range(1, 20), $urandom_range(0, 3));
      play(($urandom_range(0, 1) == 1) ? 1 : 0, "random", 1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
